// File: rtl/audio_display_pkg.sv
// Shared widths and FSM state type for the audio peak meter and its BCD converter.
package audio_display_pkg;
    localparam int SAMPLE_W   = 24;
    localparam int MAG_W      = 23;
    localparam int BCD_DIGITS = 6;
    localparam int BCD_BITS   = 19;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } meter_state_t;
endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: one shift per clock, BCD_BITS clocks after start.
module bcd_converter
    import audio_display_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BCD_BITS-1:0] bin,
    output logic [BCD_W-1:0]    bcd,
    output logic                done
);
    logic [BCD_BITS-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [BCD_W-1:0]    corrected;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        corrected = add3(bcd_q);
        if (start) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, bin_d} = {corrected[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'(BCD_BITS - 1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Final shift happens on the edge that ends this pulse.
    assign done = busy_q && (cnt_q == 5'(BCD_BITS - 1));
    assign bcd  = bcd_q;
endmodule

// File: rtl/audio_peak_meter.sv
// Windowed peak-magnitude meter driving six seven-segment digit nibbles plus a clip flag.
module audio_peak_meter
    import audio_display_pkg::*;
#(
    parameter int WINDOW = 48000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       dec_mode,
    output logic [BCD_W-1:0]           digits,
    output logic                       digits_valid,
    output logic                       clip
);
    localparam int CNT_W = $clog2(WINDOW);
    localparam logic signed [SAMPLE_W-1:0] FS_NEG = {1'b1, {MAG_W{1'b0}}};
    localparam logic signed [SAMPLE_W-1:0] FS_POS = {1'b0, {MAG_W{1'b1}}};

    meter_state_t     state_q, state_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [MAG_W-1:0] peak_q, peak_d;
    logic [MAG_W-1:0] final_peak_q, final_peak_d;
    logic             mode_q, mode_d;
    logic             full_seen_q, full_seen_d;
    logic             clip_q, clip_d;
    logic [BCD_W-1:0] digits_q, digits_d;
    logic             digits_valid_q, digits_valid_d;

    logic [MAG_W-1:0] sample_mag, peak_max;
    logic             is_full, window_end, conv_start, conv_done;
    logic [BCD_W-1:0] bcd_val;

    // The most negative sample has no positive twin; clamp it to full scale.
    function automatic logic [MAG_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] neg;
        neg = -s;
        if (s == FS_NEG) return {MAG_W{1'b1}};
        if (s < 0)       return neg[MAG_W-1:0];
        return s[MAG_W-1:0];
    endfunction

    always_comb begin
        sample_mag = sat_abs(sample);
        peak_max   = (sample_mag > peak_q) ? sample_mag : peak_q;
        is_full    = (sample == FS_POS) || (sample == FS_NEG);
        window_end = sample_valid && (win_cnt_q == CNT_W'(WINDOW - 1));
        conv_start = window_end && (state_q == IDLE);

        win_cnt_d    = win_cnt_q;
        peak_d       = peak_q;
        full_seen_d  = full_seen_q;
        final_peak_d = final_peak_q;
        mode_d       = mode_q;
        clip_d       = clip_q;
        if (sample_valid) begin
            if (window_end) begin
                win_cnt_d    = '0;
                peak_d       = '0;
                full_seen_d  = 1'b0;
                final_peak_d = peak_max;
                mode_d       = dec_mode;
                clip_d       = full_seen_q || is_full;
            end else begin
                win_cnt_d   = win_cnt_q + CNT_W'(1);
                peak_d      = peak_max;
                full_seen_d = full_seen_q || is_full;
            end
        end
    end

    bcd_converter u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (peak_max[MAG_W-1:4]),
        .bcd   (bcd_val),
        .done  (conv_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (conv_start) state_d = CONV;
            CONV:    if (conv_done)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        digits_d       = digits_q;
        digits_valid_d = 1'b0;
        if (state_q == DONE) begin
            digits_valid_d = 1'b1;
            digits_d       = mode_q ? bcd_val : {1'b0, final_peak_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q      <= '0;
            peak_q         <= '0;
            full_seen_q    <= 1'b0;
            final_peak_q   <= '0;
            mode_q         <= 1'b0;
            clip_q         <= 1'b0;
            digits_q       <= '0;
            digits_valid_q <= 1'b0;
        end else begin
            win_cnt_q      <= win_cnt_d;
            peak_q         <= peak_d;
            full_seen_q    <= full_seen_d;
            final_peak_q   <= final_peak_d;
            mode_q         <= mode_d;
            clip_q         <= clip_d;
            digits_q       <= digits_d;
            digits_valid_q <= digits_valid_d;
        end
    end

    assign digits       = digits_q;
    assign digits_valid = digits_valid_q;
    assign clip         = clip_q;
endmodule

// File: tb/tb_audio_peak_meter.sv
// Directed bench for audio_peak_meter with WINDOW=32: table of windows plus reset and gapped-valid sequences.
module tb_audio_peak_meter;
    import audio_display_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic signed [23:0] sample;
    logic               dec_mode;
    logic [23:0]        digits;
    logic               digits_valid;
    logic               clip;

    always #5 clk = ~clk;

    audio_peak_meter #(.WINDOW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .dec_mode     (dec_mode),
        .digits       (digits),
        .digits_valid (digits_valid),
        .clip         (clip)
    );

    typedef struct {
        logic [23:0] s0;
        logic [23:0] s1;
        logic [23:0] slast;
        logic        mode;
        logic [23:0] exp_d;
        logic        exp_c;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] cur_digits = '0;
    logic        cur_clip   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Feeds one 32-sample window, then watches 24 edges after E0 (optionally resetting at E0+abort_at).
    task automatic run_window(input vec_t v, input int abort_at, input string name);
        int          valid_first;
        int          valid_cnt;
        logic [23:0] d19;
        logic [23:0] d20;
        valid_first = -1;
        valid_cnt   = 0;
        d19         = '0;
        d20         = '0;
        dec_mode    = v.mode;
        for (int i = 0; i < 32; i++) begin
            sample_valid = 1'b1;
            sample       = (i == 0) ? v.s0 : (i == 1) ? v.s1 : (i == 31) ? v.slast : 24'h0;
            @(posedge clk); #1;
            if (i == 0) check({name, " clip held"}, 32'(clip), 32'(cur_clip));
        end
        sample_valid = 1'b0;
        sample       = '0;
        check({name, " clip at E0"}, 32'(clip), 32'(v.exp_c));
        for (int k = 1; k <= 24; k++) begin
            if (abort_at > 0 && k == abort_at) reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            if (digits_valid) begin
                if (valid_first < 0) valid_first = k;
                valid_cnt++;
            end
            if (k == 19) d19 = digits;
            if (k == 20) d20 = digits;
        end
        if (abort_at > 0) begin
            check({name, " no valid"}, 32'(valid_cnt), 32'd0);
            check({name, " digits"}, 32'(digits), 32'h0);
            check({name, " clip"}, 32'(clip), 32'd0);
            check({name, " state"}, 32'(dut.state_q), 32'(IDLE));
            cur_digits = '0;
            cur_clip   = 1'b0;
        end else begin
            check({name, " valid edge"}, 32'(valid_first), 32'd20);
            check({name, " valid count"}, 32'(valid_cnt), 32'd1);
            check({name, " digits before"}, 32'(d19), 32'(cur_digits));
            check({name, " digits"}, 32'(d20), 32'(v.exp_d));
            cur_digits = v.exp_d;
            cur_clip   = v.exp_c;
        end
    endtask

    initial begin
        int seen_valid;
        vecs[0] = '{24'h000100, 24'hFFEDCC, 24'h000000, 1'b0, 24'h001234, 1'b0};
        vecs[1] = '{24'h000100, 24'hFFEDCC, 24'h000000, 1'b1, 24'h000291, 1'b0};
        vecs[2] = '{24'h800000, 24'h000000, 24'h000000, 1'b1, 24'h524287, 1'b1};
        vecs[3] = '{24'h000000, 24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0};
        vecs[4] = '{24'h123456, 24'hF00000, 24'h000000, 1'b1, 24'h074565, 1'b0};
        vecs[5] = '{24'h000000, 24'h000000, 24'h800000, 1'b0, 24'h7FFFFF, 1'b1};
        vecs[6] = '{24'h000010, 24'hFFFFFF, 24'h000000, 1'b0, 24'h000010, 1'b0};
        vecs[7] = '{24'h000000, 24'h000000, 24'h7FFFFF, 1'b1, 24'h524287, 1'b1};

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        dec_mode     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset digits", 32'(digits), 32'h0);
        check("reset valid", 32'(digits_valid), 32'd0);
        check("reset clip", 32'(clip), 32'd0);
        reset = 1'b0;

        // Part of a window with full-scale samples, then reset for 2 cycles.
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1;
            sample       = 24'sh7FFFFF;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        check("midreset digits", 32'(digits), 32'h0);
        check("midreset valid", 32'(digits_valid), 32'd0);
        check("midreset clip", 32'(clip), 32'd0);
        check("midreset state", 32'(dut.state_q), 32'(IDLE));

        for (int n = 0; n < 8; n++) begin
            run_window(vecs[n], 0, $sformatf("vec%0d", n));
        end

        run_window(vecs[0], 10, "abort");
        run_window(vecs[1], 0, "after abort");

        // 25% duty valid; rejected cycles carry full-scale junk, dec_mode toggles each accepted sample.
        seen_valid = 0;
        for (int j = 0; j < 32; j++) begin
            for (int c = 0; c < 4; c++) begin
                sample_valid = (c == 3);
                sample       = (c != 3) ? 24'sh7FFFFF : (j == 5) ? 24'sd1000 : 24'sd0;
                dec_mode     = j[0];
                @(posedge clk); #1;
                if (digits_valid) seen_valid++;
            end
        end
        sample_valid = 1'b0;
        sample       = '0;
        dec_mode     = 1'b0;
        check("gapped early valid", 32'(seen_valid), 32'd0);
        check("gapped clip at E0", 32'(clip), 32'd0);
        begin
            int vf;
            logic [23:0] d20;
            vf  = -1;
            d20 = '0;
            for (int k = 1; k <= 24; k++) begin
                @(posedge clk); #1;
                if (digits_valid && vf < 0) vf = k;
                if (k == 20) d20 = digits;
            end
            check("gapped valid edge", 32'(vf), 32'd20);
            check("gapped digits", 32'(d20), 32'h000062);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
